// File: rtl/jk_bank_pkg.sv
// Shared definitions for the JK bank sequencer: command opcodes and FSM states.
package jk_bank_pkg;

   localparam logic [1:0] OP_LOAD   = 2'b00;
   localparam logic [1:0] OP_TOGGLE = 2'b01;
   localparam logic [1:0] OP_COUNT  = 2'b10;
   localparam logic [1:0] OP_CLEAR  = 2'b11;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      APPLY = 2'b01,
      COUNT = 2'b10,
      DONE  = 2'b11
   } state_e;

endpackage

// File: rtl/jk_cell.sv
// One clocked JK flip-flop with asynchronous clear; q and qbar are both registered.
module jk_cell (
   input  logic clk,
   input  logic rst_n,
   input  logic j,
   input  logic k,
   output logic q,
   output logic qbar
);

   logic q_q;
   logic qbar_q;
   logic q_d;

   // JK next-state: hold, reset, set, toggle.
   always_comb begin
      q_d = q_q;
      case ({j, k})
         2'b00:   q_d = q_q;
         2'b01:   q_d = 1'b0;
         2'b10:   q_d = 1'b1;
         2'b11:   q_d = ~q_q;
         default: q_d = q_q;
      endcase
   end

   // Store q and its complement together so qbar never lags q.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_q    <= 1'b0;
         qbar_q <= 1'b1;
      end else begin
         q_q    <= q_d;
         qbar_q <= ~q_d;
      end
   end

   assign q    = q_q;
   assign qbar = qbar_q;

endmodule

// File: rtl/jk_bank_ctrl.sv
// Command-driven sequencer for a bank of JK flip-flops (LOAD/TOGGLE/COUNT/CLEAR).
// Optional feature macro: JK_BANK_ABORT_EN adds cmd_abort, which ends a COUNT early.
module jk_bank_ctrl
   import jk_bank_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
`ifdef JK_BANK_ABORT_EN
   input  logic             cmd_abort,
`endif
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_mask,
   input  logic [WIDTH-1:0] cmd_data,
   input  logic [CNT_W-1:0] cmd_len,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] qbar,
   output logic             busy,
   output logic             done
);

   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

   state_e           state_q;
   state_e           state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic [1:0]       op_q;
   logic [WIDTH-1:0] mask_q;
   logic [WIDTH-1:0] data_q;
   logic             ready_q;
   logic             busy_q;
   logic             done_q;
   logic             handshake_s;
   logic             abort_s;
   logic             carry_s;
   logic [WIDTH-1:0] j_s;
   logic [WIDTH-1:0] k_s;

`ifdef JK_BANK_ABORT_EN
   assign abort_s = cmd_abort;
`else
   assign abort_s = 1'b0;
`endif

   // ready_q is only ever high in IDLE, so this is an IDLE-state handshake.
   assign handshake_s = cmd_valid & ready_q;

   // Next state and remaining-step counter.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (handshake_s) begin
               if ((cmd_op == OP_COUNT) && (cmd_len != CNT_ZERO)) begin
                  state_d = COUNT;
                  cnt_d   = cmd_len;
               end else begin
                  // LOAD/TOGGLE/CLEAR, and COUNT with zero length as a no-op.
                  state_d = APPLY;
               end
            end else begin
               state_d = IDLE;
            end
         end
         APPLY: begin
            state_d = DONE;
         end
         COUNT: begin
            if (abort_s) begin
               state_d = DONE;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
               if (cnt_q == CNT_ONE) begin
                  state_d = DONE;
               end else begin
                  state_d = COUNT;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            cnt_d   = CNT_ZERO;
         end
      endcase
   end

   // Per-bit J/K drive from the latched command; all-zero means hold.
   always_comb begin
      j_s     = {WIDTH{1'b0}};
      k_s     = {WIDTH{1'b0}};
      carry_s = 1'b1;
      case (state_q)
         APPLY: begin
            case (op_q)
               OP_LOAD: begin
                  j_s = mask_q & data_q;
                  k_s = mask_q & ~data_q;
               end
               OP_TOGGLE: begin
                  j_s = mask_q;
                  k_s = mask_q;
               end
               OP_CLEAR: begin
                  j_s = {WIDTH{1'b0}};
                  k_s = {WIDTH{1'b1}};
               end
               default: begin
                  // Zero-length COUNT: leave the bank untouched.
                  j_s = {WIDTH{1'b0}};
                  k_s = {WIDTH{1'b0}};
               end
            endcase
         end
         COUNT: begin
            if (!abort_s) begin
               // Ripple-carry up-count: bit i toggles when all lower bits are one.
               for (int i = 0; i < WIDTH; i++) begin
                  j_s[i]  = carry_s;
                  k_s[i]  = carry_s;
                  carry_s = carry_s & q[i];
               end
            end else begin
               j_s = {WIDTH{1'b0}};
               k_s = {WIDTH{1'b0}};
            end
         end
         default: begin
            j_s = {WIDTH{1'b0}};
            k_s = {WIDTH{1'b0}};
         end
      endcase
   end

   // FSM state, command latches and registered handshake/status outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= CNT_ZERO;
         op_q    <= OP_LOAD;
         mask_q  <= {WIDTH{1'b0}};
         data_q  <= {WIDTH{1'b0}};
         ready_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (handshake_s) begin
            op_q   <= cmd_op;
            mask_q <= cmd_mask;
            data_q <= cmd_data;
         end
         ready_q <= (state_d == IDLE);
         busy_q  <= (state_d != IDLE);
         done_q  <= (state_d == DONE);
      end
   end

   // The storage bank: one JK cell per bit.
   for (genvar g = 0; g < WIDTH; g++) begin : g_cell
      jk_cell u_cell (
         .clk  (clk),
         .rst_n(rst_n),
         .j    (j_s[g]),
         .k    (k_s[g]),
         .q    (q[g]),
         .qbar (qbar[g])
      );
   end

   assign cmd_ready = ready_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_jk_bank_ctrl.sv
// Scoreboard bench for jk_bank_ctrl: a driver issues commands and pushes the
// expected final state and completion cycle; a negedge monitor checks each done.
module tb_jk_bank_ctrl;
   import jk_bank_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [1:0] cmd_op = 2'b00;
   logic [3:0] cmd_mask = 4'h0;
   logic [3:0] cmd_data = 4'h0;
   logic [7:0] cmd_len = 8'h00;
   logic [3:0] q;
   logic [3:0] qbar;
   logic       busy;
   logic       done;
`ifdef JK_BANK_ABORT_EN
   logic       cmd_abort = 1'b0;
`endif

   jk_bank_ctrl #(.WIDTH(4), .CNT_W(8)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
`ifdef JK_BANK_ABORT_EN
      .cmd_abort(cmd_abort),
`endif
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .cmd_op   (cmd_op),
      .cmd_mask (cmd_mask),
      .cmd_data (cmd_data),
      .cmd_len  (cmd_len),
      .q        (q),
      .qbar     (qbar),
      .busy     (busy),
      .done     (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] q;
      int         h;
      int         cyc;
   } exp_t;

   exp_t       sb[$];
   int         cyc = 0;
   int         checks = 0;
   int         errors = 0;
   logic [3:0] model_q = 4'h0;
   logic       armed;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) armed <= 1'b0;
      else        armed <= 1'b1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: per-cycle invariants plus scoreboard pop on each done pulse.
   always @(negedge clk) begin
      logic [3:0] nq;
      exp_t       e;
      if (rst_n && armed) begin
         nq = ~q;
         check("qbar_inv", {28'd0, qbar}, {28'd0, nq});
         check("ready_vs_busy", {31'd0, cmd_ready}, {31'd0, ~busy});
         if (sb.size() > 0) begin
            if (cyc > sb[0].h && cyc <= sb[0].cyc) check("busy_in_cmd", {31'd0, busy}, 32'd1);
         end else begin
            check("busy_idle", {31'd0, busy}, 32'd0);
         end
         if (done) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done: got done=1 expected no pending command (t=%0t)", $time);
            end else begin
               e = sb.pop_front();
               check("done_q", {28'd0, q}, {28'd0, e.q});
               check("done_cycle", cyc, e.cyc);
            end
         end
      end
   end

   // Issue one command; abort_at>0 requests an abort on that COUNT step edge.
   task automatic send(input logic [1:0] op, input logic [3:0] m, input logic [3:0] d,
                       input logic [7:0] len, input int abort_at);
      int   n;
      int   lat;
      exp_t e;
      @(negedge clk);
      cmd_op    = op;
      cmd_mask  = m;
      cmd_data  = d;
      cmd_len   = len;
      cmd_valid = 1'b1;
      n = 0;
      while (!cmd_ready && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (n >= 400) begin
         checks++;
         errors++;
         $display("FAIL ready_timeout: got cmd_ready=0 expected 1 within 400 cycles");
      end else begin
         lat = 1;
         case (op)
            OP_LOAD:   model_q = (model_q & ~m) | (d & m);
            OP_TOGGLE: model_q = model_q ^ m;
            OP_CLEAR:  model_q = 4'h0;
            default: begin
               if (abort_at > 0) begin
                  model_q = 4'((int'(model_q) + abort_at - 1) % 16);
                  lat     = abort_at;
               end else begin
                  model_q = 4'((int'(model_q) + int'(len)) % 16);
                  if (len != 8'd0) lat = int'(len);
               end
            end
         endcase
         e.q   = model_q;
         e.h   = cyc + 1;
         e.cyc = cyc + 1 + lat;
         sb.push_back(e);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int n;
      cmd_valid = 1'b0;
      n = 0;
      while (sb.size() > 0 && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
      end
      repeat (3) @(negedge clk);
   endtask

   initial begin
      // Reset values while rst_n is held low.
      #12;
      check("rst_q", {28'd0, q}, 32'h0);
      check("rst_qbar", {28'd0, qbar}, 32'hF);
      check("rst_ready", {31'd0, cmd_ready}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      @(negedge clk);
      #2 rst_n = 1'b1;

      // Directed sequence.
      send(OP_LOAD,   4'b1111, 4'b1010, 8'd0, 0);
      send(OP_TOGGLE, 4'b0011, 4'b0000, 8'd0, 0);
      send(OP_CLEAR,  4'b0000, 4'b0000, 8'd0, 0);
      send(OP_LOAD,   4'b1111, 4'b1110, 8'd0, 0);
      send(OP_COUNT,  4'b0000, 4'b0000, 8'd3, 0);
      send(OP_LOAD,   4'b1111, 4'b0101, 8'd0, 0);
      send(OP_COUNT,  4'b1111, 4'b1111, 8'd0, 0);
      // Valid stays high through busy; the next op waits for cmd_ready.
      send(OP_TOGGLE, 4'b1000, 4'b0000, 8'd0, 0);
      drain();

      // Reset in the middle of a long COUNT.
      send(OP_COUNT, 4'b0000, 4'b0000, 8'd200, 0);
      cmd_valid = 1'b0;
      repeat (20) @(posedge clk);
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("midrst_q", {28'd0, q}, 32'h0);
      check("midrst_qbar", {28'd0, qbar}, 32'hF);
      check("midrst_busy", {31'd0, busy}, 32'd0);
      check("midrst_done", {31'd0, done}, 32'd0);
      sb.delete();
      model_q = 4'h0;
      @(negedge clk);
      #2 rst_n = 1'b1;
      repeat (5) @(negedge clk);
      send(OP_LOAD, 4'b0110, 4'b0100, 8'd0, 0);
      drain();

`ifdef JK_BANK_ABORT_EN
      // Abort on the 4th step of a COUNT of 10 from zero.
      send(OP_CLEAR, 4'b0000, 4'b0000, 8'd0, 0);
      drain();
      send(OP_COUNT, 4'b0000, 4'b0000, 8'd10, 4);
      cmd_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      cmd_abort = 1'b1;
      @(negedge clk);
      cmd_abort = 1'b0;
      drain();
      // Abort outside COUNT has no effect.
      cmd_abort = 1'b1;
      send(OP_TOGGLE, 4'b1111, 4'b0000, 8'd0, 0);
      drain();
      cmd_abort = 1'b0;
`endif

      // Randomized commands with occasional idle gaps.
      for (int i = 0; i < 40; i++) begin
         logic [1:0] op;
         logic [3:0] m;
         logic [3:0] d;
         logic [7:0] len;
         op  = 2'($urandom_range(0, 3));
         m   = 4'($urandom_range(0, 15));
         d   = 4'($urandom_range(0, 15));
         len = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(20, 40)) : 8'($urandom_range(0, 6));
         if ($urandom_range(0, 2) == 0) begin
            cmd_valid = 1'b0;
            repeat ($urandom_range(1, 4)) @(negedge clk);
         end
         send(op, m, d, len, 0);
      end
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
